// File: rtl/uart_hdr_assembler.sv
// Assembles SOF-framed, checksummed block headers from a UART byte stream into one wide word.
// Optional inter-byte timeout abort is enabled by defining UART_HDR_TIMEOUT_EN.
module uart_hdr_assembler #(
    parameter int         HDR_BYTES   = 80,
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 4_340_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_framing_err,
    output logic [HDR_BYTES*8-1:0] hdr_data,
    output logic                   hdr_valid,
    input  logic                   hdr_ready,
    output logic                   cksum_err,
    output logic                   timeout,
    output logic                   busy,
    output logic [7:0]             drop_cnt
);
    localparam int HW = HDR_BYTES * 8;
    localparam int CW = $clog2(HDR_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(HDR_BYTES - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CKSUM, HOLD} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hdr_q, hdr_d;
    logic            hdr_valid_q, hdr_valid_d;
    logic            cksum_err_q, cksum_err_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic [7:0]      drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      cks_total;
    logic            accept, bad, drop_inc;

`ifdef UART_HDR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]   tmr_q, tmr_d;
`endif

    assign accept    = rx_valid & ~rx_framing_err;
    assign bad       = rx_valid & rx_framing_err;
    assign cks_total = sum_q + rx_data;

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cksum_err_d = 1'b0;
        timeout_d   = 1'b0;
        drop_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && rx_data == SOF_BYTE) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            PAYLOAD: begin
                if (bad) begin
                    state_d  = IDLE;
                    drop_inc = 1'b1;
                end else if (accept) begin
                    hdr_d = (hdr_q << 8) | HW'(rx_data);
                    sum_d = sum_q + rx_data;
                    if (cnt_q == LAST_IDX) begin
                        state_d = CKSUM;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CKSUM: begin
                if (bad) begin
                    state_d  = IDLE;
                    drop_inc = 1'b1;
                end else if (accept) begin
                    if (cks_total == 8'h00) begin
                        state_d = HOLD;
                    end else begin
                        state_d     = IDLE;
                        cksum_err_d = 1'b1;
                        drop_inc    = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Incoming bytes are dropped here; only the consumer can release the header.
                if (hdr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_HDR_TIMEOUT_EN
        tmr_d = '0;
        if (state_q == PAYLOAD || state_q == CKSUM) begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rx_valid) begin
                tmr_d = '0;
            end else if (tmr_q == TO_MAX) begin
                state_d   = IDLE;
                timeout_d = 1'b1;
                drop_inc  = 1'b1;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
`endif

        drop_d      = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        busy_d      = (state_d != IDLE);
        hdr_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            cksum_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
`ifdef UART_HDR_TIMEOUT_EN
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            cksum_err_q <= cksum_err_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
`ifdef UART_HDR_TIMEOUT_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    assign hdr_data  = hdr_q;
    assign hdr_valid = hdr_valid_q;
    assign cksum_err = cksum_err_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
    assign drop_cnt  = drop_q;
endmodule
